// File: rtl/sat_narrow_pkg.sv
// sat_narrow_pkg: shared types and constants for the saturating narrower.
//   clamp_mode_t : selects signed or unsigned output range
//   SAT_CNT_W    : width of the saturated-beat statistics counter
package sat_narrow_pkg;

  typedef enum logic {
    CLAMP_SIGNED   = 1'b0,
    CLAMP_UNSIGNED = 1'b1
  } clamp_mode_t;

  localparam int SAT_CNT_W = 16;

endpackage

// File: rtl/sat_clamp_lane.sv
// sat_clamp_lane: combinational clamp of one shifted channel value to OUTW bits.
// Ports:
//   val_i  : INW+1-bit signed shifted value
//   mode_i : CLAMP_SIGNED or CLAMP_UNSIGNED output range
//   val_o  : clamped OUTW-bit result
//   sat_o  : high when val_i was outside the selected range
module sat_clamp_lane
  import sat_narrow_pkg::*;
#(
  parameter int INW  = 16,
  parameter int OUTW = 8
) (
  input  logic signed [INW:0]    val_i,
  input  clamp_mode_t            mode_i,
  output logic        [OUTW-1:0] val_o,
  output logic                   sat_o
);

  localparam logic signed [INW:0] SMAX = (INW+1)'((2 ** (OUTW-1)) - 1);
  localparam logic signed [INW:0] SMIN = (INW+1)'(-(2 ** (OUTW-1)));
  localparam logic signed [INW:0] UMAX = (INW+1)'((2 ** OUTW) - 1);

  always_comb begin
    val_o = val_i[OUTW-1:0];
    sat_o = 1'b0;
    if (mode_i == CLAMP_UNSIGNED) begin
      if (val_i[INW]) begin
        val_o = '0;
        sat_o = 1'b1;
      end else if (val_i > UMAX) begin
        val_o = '1;
        sat_o = 1'b1;
      end
    end else begin
      if (val_i > SMAX) begin
        val_o = {1'b0, {(OUTW-1){1'b1}}};
        sat_o = 1'b1;
      end else if (val_i < SMIN) begin
        val_o = {1'b1, {(OUTW-1){1'b0}}};
        sat_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sat_narrow_pipe.sv
// sat_narrow_pipe: two-stage, multi-channel saturating narrower with
// valid/ready handshake on both sides and saturation statistics.
//   S1 : per-channel arithmetic right shift (optionally rounded)
//   S2 : per-channel clamp to OUTW bits, signed or unsigned range
// Optional feature: define SAT_NARROW_ROUND_EN to add round-half-up before
// the shift; otherwise the shift truncates toward minus infinity.
// Ports:
//   clk, i_nrst           : clock, async active-low reset
//   i_clr                 : synchronous clear of o_satSticky / o_satCount
//   i_valid, o_ready      : input beat handshake
//   i_mode, i_shift       : clamp range and shift amount, sampled with a beat
//   i_data                : CH x INW signed input channels
//   o_valid, i_ready      : output beat handshake
//   o_data, o_satMask     : CH x OUTW clamped channels and per-channel sat flags
//   o_satSticky           : OR of consumed masks since last clear
//   o_satCount            : consumed beats with any saturation, saturating
module sat_narrow_pipe
  import sat_narrow_pkg::*;
#(
  parameter int CH   = 3,
  parameter int INW  = 16,
  parameter int OUTW = 8,
  parameter int SHW  = 4
) (
  input  logic                 clk,
  input  logic                 i_nrst,
  input  logic                 i_clr,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic                 i_mode,
  input  logic [SHW-1:0]       i_shift,
  input  logic [CH*INW-1:0]    i_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [CH*OUTW-1:0]   o_data,
  output logic [CH-1:0]        o_satMask,
  output logic [CH-1:0]        o_satSticky,
  output logic [SAT_CNT_W-1:0] o_satCount
);

  // One extra bit keeps rounding and the sign of the shifted value intact.
  localparam int VW = INW + 1;
`ifdef SAT_NARROW_ROUND_EN
  localparam logic [VW-1:0] ONE = VW'(1);
`endif

  logic s1_adv, s2_adv, in_fire, out_fire;

  logic              s1_valid_q, s1_valid_d;
  clamp_mode_t       s1_mode_q, s1_mode_d;
  logic [CH*VW-1:0]  s1_val_q, s1_val_d;
  logic signed [VW-1:0] ext;

  logic                 s2_valid_q, s2_valid_d;
  logic [CH*OUTW-1:0]   s2_data_q, s2_data_d, lane_data;
  logic [CH-1:0]        s2_mask_q, s2_mask_d, lane_sat;

  logic [CH-1:0]        sticky_q, sticky_d;
  logic [SAT_CNT_W-1:0] count_q, count_d;

  assign s2_adv   = !s2_valid_q || i_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign o_ready  = s1_adv;
  assign in_fire  = i_valid && s1_adv;
  assign out_fire = s2_valid_q && i_ready;

  // S1: sign-extend, optional rounding bias, arithmetic shift.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_mode_d  = s1_mode_q;
    s1_val_d   = s1_val_q;
    ext        = '0;
    if (s1_adv) s1_valid_d = i_valid;
    if (in_fire) begin
      s1_mode_d = clamp_mode_t'(i_mode);
      for (int c = 0; c < CH; c++) begin
        ext = {i_data[c*INW+INW-1], i_data[c*INW +: INW]};
`ifdef SAT_NARROW_ROUND_EN
        if (i_shift != '0) ext = ext + (ONE << (i_shift - 1'b1));
`endif
        s1_val_d[c*VW +: VW] = ext >>> i_shift;
      end
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_lane
    sat_clamp_lane #(
      .INW  (INW),
      .OUTW (OUTW)
    ) u_lane (
      .val_i  (s1_val_q[g*VW +: VW]),
      .mode_i (s1_mode_q),
      .val_o  (lane_data[g*OUTW +: OUTW]),
      .sat_o  (lane_sat[g])
    );
  end

  // S2: payload only reloads with a real beat so stalled output stays put.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_mask_d  = s2_mask_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = lane_data;
        s2_mask_d = lane_sat;
      end
    end
  end

  always_comb begin
    sticky_d = sticky_q;
    count_d  = count_q;
    if (out_fire) begin
      if (i_clr) begin
        sticky_d = s2_mask_q;
        count_d  = {{(SAT_CNT_W-1){1'b0}}, |s2_mask_q};
      end else begin
        sticky_d = sticky_q | s2_mask_q;
        if (|s2_mask_q && count_q != '1) count_d = count_q + 1'b1;
      end
    end else if (i_clr) begin
      sticky_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst) begin
      s1_valid_q <= 1'b0;
      s1_mode_q  <= CLAMP_SIGNED;
      s1_val_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_mask_q  <= '0;
      sticky_q   <= '0;
      count_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_mode_q  <= s1_mode_d;
      s1_val_q   <= s1_val_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_mask_q  <= s2_mask_d;
      sticky_q   <= sticky_d;
      count_q    <= count_d;
    end
  end

  assign o_valid     = s2_valid_q;
  assign o_data      = s2_data_q;
  assign o_satMask   = s2_mask_q;
  assign o_satSticky = sticky_q;
  assign o_satCount  = count_q;

endmodule

// File: doc/sat_narrow_pipe.md
# sat_narrow_pipe

Pipelined, multi-channel saturating narrower: each beat carries CH signed INW-bit values. Each value is arithmetically right-shifted by a per-beat amount, optionally rounded, then clamped to OUTW bits in signed or unsigned range. The block reports per-channel saturation and keeps saturation statistics. It sits between fixed-point datapaths (MDEC IDCT/colour conversion, GPU lighting/colour math) and narrower consumers, and uses a valid/ready handshake on both sides.

## Interface
Parameters:
- CH, 3, number of channels per beat
- INW, 16, input width per channel (signed)
- OUTW, 8, output width per channel; 2 ≤ OUTW < INW
- SHW, 4, width of shift-amount field

Ports:
- clk  in  1  clock
- i_nrst  in  1  reset; **asynchronous, active-low**
- i_clr  in  1  synchronous clear of o_satSticky and o_satCount
- i_valid  in  1  input beat valid
- o_ready  out  1  input beat accepted when i_valid && o_ready
- i_mode  in  1  0 = signed clamp, 1 = unsigned clamp
- i_shift  in  SHW  arithmetic right-shift amount
- i_data  in  CH*INW  channel c at bits [c*INW +: INW]
- o_valid  out  1  output beat valid
- i_ready  in  1  output beat consumed when o_valid && i_ready
- o_data  out  CH*OUTW  channel c at bits [c*OUTW +: OUTW]
- o_satMask  out  CH  per-channel saturation flag for the current output beat
- o_satSticky  out  CH  OR of o_satMask over all consumed beats since the last clear
- o_satCount  out  16  number of consumed beats with any o_satMask bit set; saturates at 0xFFFF

## Operation
- Stage S1 (shift): v = i_data[c] >>> i_shift, computed on INW+1 bits. A shift ≥ INW yields pure sign fill (0 or −1). Mode and the shifted values are registered.
- Stage S2 (clamp):
  - Signed mode: range −2^(OUTW−1) .. 2^(OUTW−1)−1.
  - Unsigned mode: range 0 .. 2^OUTW−1. Negatives become 0.
  - Out-of-range values go to the nearest bound, and the channel's o_satMask bit is set.
  - o_data and o_satMask are registered.
- Handshake:
  - s2_adv = !s2_valid || i_ready
  - s1_adv = !s1_valid || s2_adv
  - o_ready = s1_adv (combinational)
  - Full throughput of 1 beat/cycle. No beat is lost or reordered.
  - Output data is held stable while o_valid && !i_ready.
- Statistics are updated on a consumed beat (o_valid && i_ready):
  - If i_clr: sticky = mask; count = |mask ? 1 : 0.
  - Else: sticky |= mask; count += |mask, unless count is already 0xFFFF.
  - i_clr without a consumed beat clears both to 0.
- Reset, including mid-stream: both stages are emptied immediately. Pending beats are discarded.

## Timing
- Latency is 2 cycles from input acceptance to o_valid with i_ready held high.
- Reset values: o_valid = 0, o_data = 0, o_satMask = 0, o_satSticky = 0, o_satCount = 0. o_ready = 1 while reset is deasserted with an empty pipe.
- With i_ready low, at most 2 beats are buffered. o_ready drops in the cycle after the second accepted beat, once both stages are full.
- Statistics become visible the cycle after the consuming edge.
- i_mode and i_shift are sampled only with an accepted beat.

## Configuration
- `SAT_NARROW_ROUND_EN` defined:
  - S1 adds 2^(i_shift−1) before shifting when i_shift > 0. This is round-half-up, computed on INW+1 bits so it cannot overflow.
  - Shift 0 is unaffected.
- Macro undefined: pure truncating (floor) shift; the rounding adder is absent.

## Structure
- Package sat_narrow_pkg holds:
  - enum clamp_mode_t: CLAMP_SIGNED = 0, CLAMP_UNSIGNED = 1
  - localparam SAT_CNT_W = 16
- Sub-module sat_clamp_lane is the combinational single-channel clamp (INW+1 → OUTW, mode input, sat flag output). It is instantiated CH times in S2 via generate.
- Pipeline registers, handshake and statistics stay in the top module.

## Test plan
- **Signed clamp, shift 0:** i_data = {0xFF80, 0x0080, 0x007F} (ch2..ch0) → o_data = {0x80, 0x7F, 0x7F}; o_satMask = 3'b010.
- **Shift 4, ch0 = 0xF7FF (−2049):**
  - Without the macro: → 0x80, mask bit set.
  - With `SAT_NARROW_ROUND_EN`: → 0x80, mask clear.
  - ch1 = 0x07F0 → 0x7F, mask clear in both builds.
- **Unsigned mode:** {0x0100, 0x00FF, 0xFFFF} → {0xFF, 0xFF, 0x00}; mask = 3'b101. Shift 15 on 0x8000 → 0x00, saturated.
- **Backpressure:** 8 consecutive beats with i_ready low for cycles 2–7 → o_ready low while both stages are full; all 8 beats emerge in order with no duplicates; o_data holds stable while stalled.
- **Statistics:**
  - 65 540 saturating consumed beats → o_satCount = 0xFFFF.
  - i_clr in the same cycle as a consumed beat with mask 3'b001 → count = 1, sticky = 3'b001.
  - i_clr alone → both 0.
- **Reset mid-stream:** i_nrst low with both stages full and i_ready low → o_valid, o_data, mask, sticky and count are 0 without a clock edge. After release, the first new beat appears 2 cycles after acceptance.
